floatb_conv: RTL and testbench
==============================

// Module: floatb_conv
// PURPOSE
// - Converts a 16-bit two's-complement reconstructed signal SR into the 11-bit
//   floating-point format SR0 used by the G.726 ADPCM pole-predictor path.
// - Output format: {sign(1), exponent(4), mantissa(6)}.
// - Sits between the reconstruction adder and the FMULT/predictor delay line.
// - Registered output with one-cycle latency.
// PARAMETERS
// - IN_W    16  input word width (fixed by G.726; other values unsupported)
// - EXP_W    4  exponent field width
// - MANT_W   6  mantissa field width
// PORTS
// - clk        in   1   single clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - in_valid   in   1   sr/law qualify this cycle
// - sr         in   16  reconstructed signal, two's complement
// - law        in   1   A/u-law select; no effect on conversion, only registered
//                       through alongside the result
// - out_valid  out  1   sr0/law_o valid
// - sr0        out  11  floating-point result {srs, exp[3:0], mant[5:0]}
// - law_o      out  1   registered copy of law
// BEHAVIOUR
// - Reset (async assert, sync release): out_valid=0, sr0=11'h000, law_o=0.
// - Conversion (combinational, then registered):
//   - srs = sr[15].
//   - mag = srs ? ((17'd65536 - sr) & 15'h7FFF) : sr[14:0], 15 bits.
//   - exp = position of the leading one of mag, plus 1; exp=0 when mag=0.
//     Examples: mag>=16384 -> 15; 8192..16383 -> 14; mag=1 -> 1.
//   - mant = (mag==0) ? 6'd32 : ({mag,6'b0} >> exp)[5:0].
//     - Use a 21-bit intermediate.
//     - For nonzero mag, mant is always in 32..63 (MSB set).
//   - sr0 = {srs, exp, mant}, i.e. (srs<<10) + (exp<<6) + mant.
// - Timing and handshake:
//   - Latency is 1 cycle. If in_valid is high at edge N, sr0, law_o and
//     out_valid=1 appear after edge N.
//   - If in_valid is low at an edge: out_valid goes to 0, and sr0/law_o hold
//     their previous value.
//   - No backpressure. A new sample is accepted every cycle.
// - Boundaries:
//   - sr=16'h8000: the mask yields mag=0. Result is sr0=11'h420
//     (sign 1, exp 0, mant 32). No saturation.
//   - sr=0: sr0=11'h020.
//   - Negative zero cannot occur. srs follows sr[15] only.
//   - Reset asserted mid-stream clears outputs immediately. The first valid
//     output after release needs a fresh in_valid.
// STRUCTURE
// - Package floatb_pkg holds:
//   - IN_W, EXP_W and MANT_W localparams.
//   - SR0_W = 1+EXP_W+MANT_W.
//   - A packed struct typedef {srs, exp, mant} for sr0.
// - Sub-module floatb_lod: combinational 15-bit leading-one detector returning
//   exp (0..15).
// - Top level: magnitude logic, barrel shift for mant, pack, output register.
// TESTING
// - Zero and unity inputs:
//   - sr=16'h0000 -> sr0=11'h020.
//   - sr=16'h0001 -> sr0=11'h060 (exp 1, mant 32).
// - Positive extremes:
//   - sr=16'h7FFF -> sr0=11'h3FF (exp 15, mant 63).
//   - sr=16'h0100 -> sr0=11'h260 (exp 9, mant 32).
// - Negatives:
//   - sr=16'hFFFF -> sr0=11'h460.
//   - sr=16'h8000 -> sr0=11'h420.
//   - sr=16'hFF00 (-256) -> sr0=11'h660.
// - Handshake:
//   - Drive in_valid for 3 cycles, then low.
//   - out_valid is high for exactly 3 cycles, each delayed by 1 cycle.
//   - sr0 holds the last result while out_valid is low.
//   - law=1 with a sample -> law_o=1 on the same output cycle.
// - Reset mid-stream: assert rst_n=0 between clock edges.
//   - out_valid=0, sr0=0 and law_o=0 immediately, with no clock edge needed.
// - Random sweep of 1000 samples against a reference model of the formula
//   above, including all 16 exponent boundaries 2^k-1 and 2^k for both signs.

Source files
------------

// File: rtl/floatb_pkg.sv
// Field widths and the packed SR0 layout shared by the G.726 float converter.
package floatb_pkg;

  localparam int IN_W   = 16;
  localparam int EXP_W  = 4;
  localparam int MANT_W = 6;
  localparam int MAG_W  = IN_W - 1;
  localparam int SR0_W  = 1 + EXP_W + MANT_W;

  // A zero magnitude still carries the implicit leading one in the mantissa.
  localparam logic [MANT_W-1:0] MANT_ZERO = 6'd32;

  typedef struct packed {
    logic              srs;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } sr0_t;

endpackage

// File: rtl/floatb_lod.sv
// 15-bit leading-one detector: returns bit position of the leading one plus 1, 0 for zero.
// Purely combinational; no handshake.
module floatb_lod
  import floatb_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  output logic [EXP_W-1:0] exp
);

  always_comb begin
    exp = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) exp = EXP_W'(i + 1);
    end
  end

endmodule

// File: rtl/floatb_conv.sv
// SR (16-bit two's complement) to SR0 {sign, exp, mant} float, registered with 1-cycle latency.
// No backpressure: a sample is taken on every cycle in_valid is high.
module floatb_conv
  import floatb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   sr,
  input  logic              law,
  output logic              out_valid,
  output logic [SR0_W-1:0]  sr0,
  output logic              law_o
);

  logic                    srs;
  logic [MAG_W-1:0]        mag;
  logic [EXP_W-1:0]        exp;
  logic [MAG_W+MANT_W-1:0] shifted;
  logic                    shift_unused;
  sr0_t                    sr0_d;
  sr0_t                    sr0_q;
  logic                    out_valid_q;
  logic                    law_q;

  assign srs = sr[IN_W-1];

  // Negation truncated to 15 bits, so -32768 folds to a zero magnitude.
  assign mag = srs ? (~sr[MAG_W-1:0] + MAG_W'(1)) : sr[MAG_W-1:0];

  floatb_lod u_lod (
    .mag (mag),
    .exp (exp)
  );

  assign shifted      = {mag, {MANT_W{1'b0}}} >> exp;
  assign shift_unused = ^shifted[MAG_W+MANT_W-1:MANT_W];

  always_comb begin
    sr0_d      = '0;
    sr0_d.srs  = srs;
    sr0_d.exp  = exp;
    sr0_d.mant = (mag == '0) ? MANT_ZERO : shifted[MANT_W-1:0];
  end

  // Result and law hold across idle cycles; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sr0_q       <= '0;
      law_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        sr0_q <= sr0_d;
        law_q <= law;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sr0       = sr0_q;
  assign law_o     = law_q;

endmodule

// File: tb/tb_floatb_conv.sv
// Scoreboard bench for floatb_conv: directed vectors, handshake, mid-stream reset, random sweep.
module tb_floatb_conv;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] sr;
  logic        law;
  logic        out_valid;
  logic [10:0] sr0;
  logic        law_o;

  typedef struct {
    logic [10:0] sr0;
    logic        law;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   n_out;
  logic [10:0] last_sr0;
  logic        last_law;

  floatb_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sr        (sr),
    .law       (law),
    .out_valid (out_valid),
    .sr0       (sr0),
    .law_o     (law_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: value-level arithmetic on the integer magnitude.
  function automatic logic [10:0] ref_model(input logic [15:0] s);
    int v, m, e, mant, sgn;
    v   = int'({16'd0, s});
    sgn = (v >= 32768) ? 1 : 0;
    m   = sgn ? ((65536 - v) % 32768) : v;
    e   = 0;
    while (e < 15 && (1 << e) <= m) e++;
    mant = (m == 0) ? 32 : (m * 64) / (1 << e);
    return 11'(sgn * 1024 + e * 64 + mant);
  endfunction

  // Inputs change just after the falling edge, once the monitor has sampled.
  task automatic send(input logic [15:0] s, input logic l, input logic [10:0] e_sr0);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    sr       = s;
    law      = l;
    e.sr0    = e_sr0;
    e.law    = l;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      sr       = 16'($urandom);
      law      = 1'($urandom);
    end
  endtask

  // Monitor: one cycle after issue the sample must be on the output.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sr0 = '0;
      last_law = 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
        last_sr0 = sr0;
        last_law = law_o;
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        chk("sr0", sr0, e.sr0);
        chk("law_o", law_o, e.law);
        last_sr0 = e.sr0;
        last_law = e.law;
      end
    end else begin
      chk("missing_out_valid", sb.size(), 0);
      chk("sr0_hold", sr0, last_sr0);
      chk("law_o_hold", law_o, last_law);
    end
  end

  logic [15:0] bnd[64];

  initial begin
    checks   = 0;
    failures = 0;
    n_out    = 0;
    in_valid = 1'b0;
    sr       = '0;
    law      = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sr0", sr0, 0);
    chk("reset_law_o", law_o, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Directed vectors with hand-derived results.
    send(16'h0000, 1'b0, 11'h020);
    send(16'h0001, 1'b0, 11'h060);
    send(16'h7FFF, 1'b1, 11'h3FF);
    send(16'h0100, 1'b0, 11'h260);
    send(16'hFFFF, 1'b1, 11'h460);
    send(16'h8000, 1'b0, 11'h420);
    send(16'hFF00, 1'b0, 11'h660);
    idle(3);

    // Three back-to-back samples then idle: exactly three outputs, then hold.
    begin
      int n0;
      n0 = n_out;
      send(16'h1234, 1'b1, ref_model(16'h1234));
      send(16'hC000, 1'b0, ref_model(16'hC000));
      send(16'h0003, 1'b1, ref_model(16'h0003));
      idle(4);
      chk("handshake_count", n_out - n0, 3);
    end

    // Asynchronous reset between edges while an output is being presented.
    send(16'h4000, 1'b1, 11'h3E0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_sr0", sr0, 0);
    chk("midreset_law_o", law_o, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send(16'hFFFE, 1'b1, 11'h4A0);
    idle(2);

    // Exponent boundaries 2^k-1 and 2^k, both signs, then random fill.
    for (int k = 0; k < 16; k++) begin
      int p1, p2;
      p1 = (1 << k) - 1;
      p2 = 1 << k;
      bnd[4*k+0] = 16'(p1);
      bnd[4*k+1] = 16'(p2);
      bnd[4*k+2] = 16'((65536 - p1) % 65536);
      bnd[4*k+3] = 16'((65536 - p2) % 65536);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] s;
      s = (i < 64) ? bnd[i] : 16'($urandom);
      if ($urandom_range(3) == 0) idle(1);
      send(s, 1'($urandom), ref_model(s));
    end
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
